fp_div_iter: RTL and testbench



---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_unpack.sv | 30 +++
 rtl/fp_div_iter.sv | 209 ++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the iterative IEEE754 divider (fp_div_iter).
package fp_pkg;

  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_t;

  typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} div_state_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN right-aligned in a 64-bit word; callers truncate to their width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= man_w - 1 && i < man_w + exp_w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE754 operand into fields and classifies it; subnormals read as zero.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [MAN_W-1:0]     frac,
  output fp_class_t            cls
);

  assign sign     = x[EXP_W+MAN_W];
  assign exponent = x[EXP_W+MAN_W-1:MAN_W];
  assign frac     = x[MAN_W-1:0];

  always_comb begin
    cls = NORM;
    if (exponent == '0) begin
      cls = ZERO;
    end else if (exponent == '1) begin
      if (frac == '0)          cls = INF;
      else if (frac[MAN_W-1])  cls = QNAN;
      else                     cls = SNAN;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE754 divider: radix-2 restoring mantissa divide, RNE rounding, flush-to-zero.
// Define FP_DIV_FLAGS_EN to add the {NV,DZ,OF,UF,NX} exception flag output.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]   flags
`endif
);

  localparam int BIAS  = fp_bias(EXP_W);
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [W-1:0]          QNAN_VAL = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] EMAX     = EW2'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAN_W + 2);

  div_state_t state, state_n;

  logic [W-1:0]       a_r, b_r;
  logic               sa, sb, sx;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fp_class_t          ca, cb;
  logic               a_nan, b_nan;

  logic                  sign_r;
  logic signed [EW2-1:0] e_r;
  logic [MAN_W+1:0]      rem, rem_sub;
  logic                  rem_ge;
  logic [MAN_W:0]        div;
  logic [MAN_W+2:0]      q;
  logic [CNT_W-1:0]      cnt;

  logic               special, special_r;
  logic [W-1:0]       spec_res, spec_r;

  logic                  msb, guard, rbit, sticky, round_up, ovf, unf;
  logic [MAN_W:0]        mant;
  logic [MAN_W+1:0]      mant_r;
  logic signed [EW2-1:0] e_n, e_f;
  logic [W-1:0]          rnd_res;

`ifdef FP_DIV_FLAGS_EN
  logic [4:0] spec_fl, spec_fl_r, rnd_fl;
  logic       inexact;
`endif

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a_r), .sign(sa), .exponent(ea), .frac(fa), .cls(ca)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b_r), .sign(sb), .exponent(eb), .frac(fb), .cls(cb)
  );

  assign sx    = sa ^ sb;
  assign a_nan = (ca == QNAN) || (ca == SNAN);
  assign b_nan = (cb == QNAN) || (cb == SNAN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = UNPACK;
      end
      UNPACK: state_n = special ? ROUND : ITER;
      ITER:   if (cnt == CNT_LAST) state_n = ROUND;
      ROUND:  state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Special operands resolve here; the value waits in spec_r and is committed in ROUND.
  always_comb begin
    special  = 1'b1;
    spec_res = '0;
`ifdef FP_DIV_FLAGS_EN
    spec_fl  = '0;
`endif
    if (a_nan || b_nan || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
      spec_res = QNAN_VAL;
`ifdef FP_DIV_FLAGS_EN
      spec_fl[FLAG_NV] = (ca == SNAN) || (cb == SNAN) ||
                         (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF);
`endif
    end else if (cb == ZERO) begin
      spec_res = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      spec_fl[FLAG_DZ] = (ca == NORM);
`endif
    end else if (ca == INF) begin
      spec_res = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == ZERO || cb == INF) begin
      spec_res = {sx, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  assign rem_ge  = rem >= {1'b0, div};
  assign rem_sub = rem - {1'b0, div};

  // q holds 1 integer bit plus MAN_W+2 fraction bits; rem keeps the exact remainder for sticky.
  always_comb begin
    msb      = q[MAN_W+2];
    mant     = msb ? q[MAN_W+2:2] : q[MAN_W+1:1];
    guard    = msb ? q[1] : q[0];
    rbit     = msb & q[0];
    sticky   = |rem;
    round_up = guard & (rbit | sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    e_n      = msb ? e_r : e_r - EW2'(1);
    e_f      = e_n + EW2'(mant_r[MAN_W+1]);
    ovf      = e_f >= EMAX;
    unf      = !ovf && (e_f[EW2-1] || e_f == '0);
    if (ovf)      rnd_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf) rnd_res = {sign_r, {(W-1){1'b0}}};
    else          rnd_res = {sign_r, e_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
`ifdef FP_DIV_FLAGS_EN
    inexact          = guard | rbit | sticky;
    rnd_fl           = '0;
    rnd_fl[FLAG_OF]  = ovf;
    rnd_fl[FLAG_UF]  = unf;
    rnd_fl[FLAG_NX]  = inexact | ovf | unf;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      e_r       <= '0;
      rem       <= '0;
      div       <= '0;
      q         <= '0;
      cnt       <= '0;
      special_r <= 1'b0;
      spec_r    <= '0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          special_r <= special;
          spec_r    <= spec_res;
          sign_r    <= sx;
          e_r       <= EW2'(int'(ea) - int'(eb) + BIAS);
          rem       <= {1'b0, 1'b1, fa};
          div       <= {1'b1, fb};
          q         <= '0;
          cnt       <= '0;
        end
        ITER: begin
          rem <= rem_ge ? {rem_sub[MAN_W:0], 1'b0} : {rem[MAN_W:0], 1'b0};
          q   <= {q[MAN_W+1:0], rem_ge};
          cnt <= cnt + CNT_W'(1);
        end
        ROUND: result <= special_r ? spec_r : rnd_res;
        default: ;
      endcase
    end
  end

`ifdef FP_DIV_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_fl_r <= '0;
      flags     <= '0;
    end else begin
      if (state == UNPACK) spec_fl_r <= spec_fl;
      if (state == ROUND)  flags     <= special_r ? spec_fl_r : rnd_fl;
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter in binary32 and binary16 builds.
`timescale 1ns/1ps
module tb_fp_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, result_h;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags, flags_h, last_flags;
`endif

  int checks = 0;
  int fails  = 0;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FP_DIV_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .out_valid(out_valid_h), .out_ready(out_ready_h), .result(result_h)
`ifdef FP_DIV_FLAGS_EN
    , .flags(flags_h)
`endif
  );

  // Issue one binary32 op; lat counts posedges from acceptance to out_valid (0 = timed out).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit ack,
                        output logic [31:0] res, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = result;
`ifdef FP_DIV_FLAGS_EN
    last_flags = flags;
`endif
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic run_op_h(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] res, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (in_ready_h !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    a_h = av;
    b_h = bv;
    in_valid_h = 1'b1;
    @(posedge clk);
    #1 in_valid_h = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_h === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = result_h;
    out_ready_h = 1'b1;
    @(posedge clk);
    #1 out_ready_h = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid_h = 1'b0; out_ready_h = 1'b0; a_h = '0; b_h = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (result !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    checks++;
    if (in_ready_h !== 1'b1 || out_valid_h !== 1'b0 || result_h !== 16'h0) begin
      fails++;
      $display("[TB] FAIL reset_half: got ready=%b valid=%b result=%h expected 1/0/0000",
               in_ready_h, out_valid_h, result_h);
    end
`ifdef FP_DIV_FLAGS_EN
    checks++;
    if (flags !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", flags);
    end
`endif
  endtask

  task automatic test_normal();
    logic [31:0] res;
    int lat;
    run_op(32'h40C00000, 32'h40000000, 1'b1, res, lat);
    checks++;
    if (res !== 32'h40400000) begin
      fails++; $display("[TB] FAIL div_6_2: got %h expected 40400000", res);
    end
    checks++;
    if (lat !== 28) begin
      fails++; $display("[TB] FAIL latency_6_2: got %0d expected 28", lat);
    end
`ifdef FP_DIV_FLAGS_EN
    checks++;
    if (last_flags !== 5'b00000) begin
      fails++; $display("[TB] FAIL flags_6_2: got %b expected 00000", last_flags);
    end
`endif
    run_op(32'h3F800000, 32'h40400000, 1'b1, res, lat);
    checks++;
    if (res !== 32'h3EAAAAAB) begin
      fails++; $display("[TB] FAIL div_1_3: got %h expected 3eaaaaab", res);
    end
`ifdef FP_DIV_FLAGS_EN
    checks++;
    if (last_flags !== 5'b00001) begin
      fails++; $display("[TB] FAIL flags_1_3: got %b expected 00001", last_flags);
    end
`endif
  endtask

  task automatic test_special();
    logic [31:0] ta [3] = '{32'h3F800000, 32'h00000000, 32'hBFC00000};
    logic [31:0] tb [3] = '{32'h00000000, 32'h00000000, 32'h7F800000};
    logic [31:0] te [3] = '{32'h7F800000, 32'h7FC00000, 32'h80000000};
    logic [4:0]  tf [3] = '{5'b01000, 5'b10000, 5'b00000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b1, res, lat);
      checks++;
      if (res !== te[i]) begin
        fails++; $display("[TB] FAIL special_%0d_result: got %h expected %h", i, res, te[i]);
      end
      checks++;
      if (lat !== 2) begin
        fails++; $display("[TB] FAIL special_%0d_latency: got %0d expected 2", i, lat);
      end
`ifdef FP_DIV_FLAGS_EN
      checks++;
      if (last_flags !== tf[i]) begin
        fails++; $display("[TB] FAIL special_%0d_flags: got %b expected %b", i, last_flags, tf[i]);
      end
`else
      if (tf[i] === 5'b11111) $display("[TB] note: unused flag vector %0d", i);
`endif
    end
  endtask

  task automatic test_range();
    logic [31:0] ta [2] = '{32'h7F000000, 32'h00800000};
    logic [31:0] tb [2] = '{32'h3E800000, 32'h40000000};
    logic [31:0] te [2] = '{32'h7F800000, 32'h00000000};
    logic [4:0]  tf [2] = '{5'b00101, 5'b00011};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb[i], 1'b1, res, lat);
      checks++;
      if (res !== te[i]) begin
        fails++; $display("[TB] FAIL range_%0d_result: got %h expected %h", i, res, te[i]);
      end
`ifdef FP_DIV_FLAGS_EN
      checks++;
      if (last_flags !== tf[i]) begin
        fails++; $display("[TB] FAIL range_%0d_flags: got %b expected %b", i, last_flags, tf[i]);
      end
`else
      if (tf[i] === 5'b11111) $display("[TB] note: unused flag vector %0d", i);
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    int bad;
    run_op(32'h40C00000, 32'h40000000, 1'b0, res, lat);
    checks++;
    if (res !== 32'h40400000 || lat !== 28) begin
      fails++; $display("[TB] FAIL bp_first: got %h lat %0d expected 40400000 lat 28", res, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = 32'h40400000;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b result=%h ready=%b expected 1/40400000/0",
                 i, out_valid, result, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("[TB] FAIL bp_ignored_input: got %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    int bad;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_state: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("[TB] FAIL midreset_no_result: got %0d valid cycles expected 0", bad);
    end
    run_op(32'hC0900000, 32'h3FC00000, 1'b1, res, lat);
    checks++;
    if (res !== 32'hC0400000) begin
      fails++; $display("[TB] FAIL midreset_next_op: got %h expected c0400000", res);
    end
    checks++;
    if (lat !== 28) begin
      fails++; $display("[TB] FAIL midreset_latency: got %0d expected 28", lat);
    end
  endtask

  task automatic test_half();
    logic [15:0] res;
    int lat;
    run_op_h(16'h4600, 16'h4000, res, lat);
    checks++;
    if (res !== 16'h4200) begin
      fails++; $display("[TB] FAIL half_6_2: got %h expected 4200", res);
    end
    checks++;
    if (lat !== 15) begin
      fails++; $display("[TB] FAIL half_latency: got %0d expected 15", lat);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting fp_div_iter bench");
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_op();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
